db9_md_pad_scanner: RTL
=======================

Name: db9_md_pad_scanner

Overview:
- Sequences the DB9 select line to read a Mega Drive 3/6-button pad, or a plain 2-button DB9 joystick, through a single 6-pin input bus.
- Decodes the pins into a 12-bit negative-logic button word, applies 2-scan agreement filtering, and publishes it atomically once per scan.
- Sits between the top-level DB9 pins (joy_in, db9_select) and the core input mux in place of free-running select toggling.

Parameters:
- STEP_CYCLES, 480, clk_sys cycles per select phase (10 us at 48 MHz); minimum 2.
- SCAN_PERIOD, 96000, clk_sys cycles from one scan start to the next (2 ms); effective period = max(SCAN_PERIOD, 8*STEP_CYCLES+1).

Ports:
- clk_sys  in  1  system clock (48 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scanning allowed; sampled only in IDLE.
- joy_in  in  6  raw pins, active-low: [5]=pin9 (C/Start), [4]=pin6 (B/A), [3]=U/Z, [2]=D/Y, [1]=L/X, [0]=R/Mode.
- db9_select  out  1  pad select (pin 7).
- joy_out  out  12  MXYZ SACB RLDU, negative logic (0 = pressed).
- six_btn  out  1  last committed scan detected a 6-button pad.
- present  out  1  last committed scan detected an MD pad (3- or 6-button).
- scan_done  out  1  one-cycle pulse when a scan completes.

Behaviour:
- Reset (asynchronous, any time, including mid-scan): db9_select=1, joy_out=12'hFFF, six_btn=0, present=0, scan_done=0, FSM=IDLE, all counters=0, candidate word=12'hFFF.
- FSM states: IDLE, PHASE (phase index p=0..7), COMMIT.
- IDLE: db9_select=1; period counter increments each cycle.
  - When period counter >= effective period - 1 and enable=1: go to PHASE with p=0, step counter=0, period counter=0.
  - If enable=0: stay in IDLE; period counter saturates.
- PHASE: db9_select = 1 when p is even, 0 when p is odd; the step counter counts 0..STEP_CYCLES-1.
  - On the last step cycle, joy_in is sampled (setup time = STEP_CYCLES-1 cycles after the edge).
  - Then p increments, or the FSM goes to COMMIT after p=7.
  - The period counter keeps running during PHASE.
- Sample decode (pin value 0 = pressed or low):
  - p=0: U=[3], D=[2], L=[1], R=[0], B=[4], C=[5].
  - p=1: A=[4], S=[5]; md_det = ([1]==0 && [0]==0).
  - p=5: six_det = ([3:0]==4'b0000).
  - p=6: Z=[3], Y=[2], X=[1], M=[0].
  - Other phases are not sampled.
- Word assembly:
  - If md_det=0: A, S, M, X, Y, Z forced to 1 (released).
  - If md_det=0 or six_det=0: M, X, Y, Z forced to 1.
  - six_det is valid only when md_det=1.
- COMMIT (one cycle):
  - If the new word equals the candidate word: joy_out <= new word, present <= md_det, six_btn <= md_det & six_det.
  - Otherwise outputs are unchanged.
  - In both cases the candidate word <= new word, scan_done=1, and the FSM returns to IDLE with db9_select=1.
- Latency: a stable input appears on joy_out at the COMMIT of the second consecutive scan that sees it. Worst case from a pin change is about 2 effective periods + 8*STEP_CYCLES.
- enable deasserted mid-scan: the scan completes normally; the FSM stops at the next IDLE.
- db9_select toggles only at phase boundaries; it is never glitched and is registered.
- Idle high time = effective period - 8*STEP_CYCLES. At defaults this is 1.92 ms, above the 1.5 ms pad counter timeout.

Test Plan:
- Reset asserted mid-PHASE (p=3) -> db9_select=1 within the same cycle (async), joy_out=FFF, six_btn=0, present=0; scanning restarts after the effective period.
- 6-button model, A+Z held -> first scan: joy_out=FFF and select shows 8 phases of 480 cycles; second scan COMMIT: joy_out=12'hEBF (Z, A low), six_btn=1, present=1, single scan_done pulse.
- 3-button model (p=5 returns U=0 only), C+Up held -> after 2 scans joy_out=12'hFDE, present=1, six_btn=0; X/Y/Z/M stay 1 even if the pins read 0 at p=6.
- Plain 2-button stick (no L/R low at p=1), B pressed plus Left, with pin9 low at p=1 -> joy_out=12'hFEB, present=0; Start and A not reported.
- Button pressed for exactly one scan, then released -> joy_out never changes from FFF; a button held for 3 scans appears at the 2nd COMMIT.
- enable=0 during p=4 with SCAN_PERIOD=100, STEP_CYCLES=20 -> the scan finishes, the effective period is 161, select stays 1 indefinitely; enable=1 starts the next scan immediately (period counter saturated).

Source files
------------

// File: rtl/db9_md_pad_scanner.sv
// Mega Drive 3/6-button pad / DB9 joystick scanner: drives pin-7 select through 8 phases per scan,
// decodes the samples and publishes a 2-scan-agreement filtered negative-logic button word.
module db9_md_pad_scanner #(
  parameter int unsigned STEP_CYCLES = 480,
  parameter int unsigned SCAN_PERIOD = 96000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [5:0]  joy_in,
  output logic        db9_select,
  output logic [11:0] joy_out,
  output logic        six_btn,
  output logic        present,
  output logic        scan_done
);

  localparam int unsigned MinPeriod = 8 * STEP_CYCLES + 1;
  localparam int unsigned EffPeriod = (SCAN_PERIOD > MinPeriod) ? SCAN_PERIOD : MinPeriod;
  localparam int unsigned PerW      = $clog2(EffPeriod);
  localparam int unsigned StepW     = $clog2(STEP_CYCLES);
  localparam logic [PerW-1:0]  PeriodLast = PerW'(EffPeriod - 1);
  localparam logic [StepW-1:0] StepLast   = StepW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPhase, StCommit} state_e;

  state_e            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [StepW-1:0]  step_q, step_d;
  logic [PerW-1:0]   period_q, period_d;
  logic              sel_q, sel_d;
  logic              sample_en;

  // Raw active-low samples: dpad = {U, D, L, R}, zyxm = {Z, Y, X, M}
  logic [3:0]        dpad_q, zyxm_q;
  logic              b_q, c_q, a_q, s_q;
  logic              md_det_q, six_det_q;
  logic [11:0]       cand_q, joy_q, new_word;
  logic              six_q, present_q, six_ok;

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      step_q   <= '0;
      period_q <= '0;
      sel_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      step_q   <= step_d;
      period_q <= period_d;
      sel_q    <= sel_d;
    end
  end

  // Next-state logic; the period counter saturates so a held-off scan starts at once on enable
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    step_d    = step_q;
    period_d  = (period_q >= PeriodLast) ? period_q : period_q + PerW'(1);
    sample_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && (period_q >= PeriodLast)) begin
          state_d  = StPhase;
          phase_d  = '0;
          step_d   = '0;
          period_d = '0;
        end
      end
      StPhase: begin
        if (step_q == StepLast) begin
          sample_en = 1'b1;
          step_d    = '0;
          if (phase_q == 3'd7) state_d = StCommit;
          else                 phase_d = phase_q + 3'd1;
        end else begin
          step_d = step_q + StepW'(1);
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    sel_d = (state_d == StPhase) ? ~phase_d[0] : 1'b1;
  end

  // Output logic
  always_comb begin
    six_ok    = md_det_q & six_det_q;
    new_word  = {six_ok ? {zyxm_q[0], zyxm_q[1], zyxm_q[2], zyxm_q[3]} : 4'hF,
                 md_det_q ? {s_q, a_q} : 2'b11,
                 c_q, b_q, dpad_q[0], dpad_q[1], dpad_q[2], dpad_q[3]};
    scan_done  = (state_q == StCommit);
    db9_select = sel_q;
    joy_out    = joy_q;
    six_btn    = six_q;
    present    = present_q;
  end

  // Phase samples and filtered publication
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dpad_q    <= 4'hF;
      zyxm_q    <= 4'hF;
      b_q       <= 1'b1;
      c_q       <= 1'b1;
      a_q       <= 1'b1;
      s_q       <= 1'b1;
      md_det_q  <= 1'b0;
      six_det_q <= 1'b0;
      cand_q    <= 12'hFFF;
      joy_q     <= 12'hFFF;
      six_q     <= 1'b0;
      present_q <= 1'b0;
    end else begin
      if (sample_en) begin
        case (phase_q)
          3'd0: begin
            dpad_q <= joy_in[3:0];
            b_q    <= joy_in[4];
            c_q    <= joy_in[5];
          end
          3'd1: begin
            a_q      <= joy_in[4];
            s_q      <= joy_in[5];
            md_det_q <= (joy_in[1:0] == 2'b00);
          end
          3'd5: six_det_q <= (joy_in[3:0] == 4'b0000);
          3'd6: zyxm_q    <= joy_in[3:0];
          default: ;
        endcase
      end
      if (state_q == StCommit) begin
        cand_q <= new_word;
        if (new_word == cand_q) begin
          joy_q     <= new_word;
          present_q <= md_det_q;
          six_q     <= six_ok;
        end
      end
    end
  end

endmodule
